// File: rtl/legv8_multicycle_ctrl_if.sv
// legv8_multicycle_ctrl_if: control-word and instruction/status bundle between the LEGv8 sequencer and its datapath
//   run, inst, prestat      : datapath/ROM -> sequencer (run request, ROM word at PC, registered ALU flags)
//   sa, sb, da, wr          : register file read selects, write select, write enable
//   fs, c0, k, m            : ALU function, carry-in, constant, B-input mux (1 = k)
//   en_alu .. en_addr_pc    : tri-state bus enables
//   pc_sel, ps              : PC source (1 = k) and PC mode (00 hold, 01 +1, 10 load, 11 add k)
//   rcs, rwe, roe, sfl      : RAM chip select / write / output enable, status load
//   halted, state           : halt indicator and debug state
interface legv8_multicycle_ctrl_if;
    logic        run;
    logic [31:0] inst;
    logic [3:0]  prestat;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic        wr;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        m;
    logic        en_alu;
    logic        en_addr_alu;
    logic        en_b;
    logic        en_pc;
    logic        en_addr_pc;
    logic        pc_sel;
    logic [1:0]  ps;
    logic        rcs;
    logic        rwe;
    logic        roe;
    logic        sfl;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  run, inst, prestat,
        output sa, sb, da, wr, fs, c0, k, m, en_alu, en_addr_alu, en_b, en_pc, en_addr_pc,
               pc_sel, ps, rcs, rwe, roe, sfl, halted, state
    );

    modport slave (
        output run, inst, prestat,
        input  sa, sb, da, wr, fs, c0, k, m, en_alu, en_addr_alu, en_b, en_pc, en_addr_pc,
               pc_sel, ps, rcs, rwe, roe, sfl, halted, state
    );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: multi-cycle LEGv8 sequencer driving the datapath control word one state per cycle
//   clk : rising-edge clock
//   rst : synchronous active-low reset (state FETCH, IR cleared, all outputs 0)
//   bus : legv8_multicycle_ctrl_if.master (run/inst/prestat in, full control word, halted and state out)
//   state encoding on bus.state: FETCH 0, DECODE 1, EXR 2, EXI 3, LD1 4, LD2 5, ST 6, BR 7,
//   CB1 8, CB2 9, HALT 10
module legv8_multicycle_ctrl #(
    parameter logic [4:0] FS_ADD = 5'b00100,
    parameter logic [4:0] FS_SUB = 5'b00101,
    parameter logic [4:0] FS_AND = 5'b00000,
    parameter logic [4:0] FS_ORR = 5'b00001,
    parameter int         Z_BIT  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    legv8_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXR    = 4'd2,
        EXI    = 4'd3,
        LD1    = 4'd4,
        LD2    = 4'd5,
        ST     = 4'd6,
        BR     = 4'd7,
        CB1    = 4'd8,
        CB2    = 4'd9,
        HALT   = 4'd10
    } state_t;

    state_t      st;
    logic [31:0] ir;
    logic        halt_q;

    logic is_add, is_sub, is_and, is_orr, is_addi, is_subi;
    logic is_ldur, is_stur, is_b, is_cbz, is_r, is_i;
    logic [4:0]  alu_fs;
    logic [63:0] k_d9, k_i12, k_b26, k_cb19;

    assign is_add  = ir[31:21] == 11'b10001011000;
    assign is_sub  = ir[31:21] == 11'b11001011000;
    assign is_and  = ir[31:21] == 11'b10001010000;
    assign is_orr  = ir[31:21] == 11'b10101010000;
    assign is_addi = ir[31:22] == 10'b1001000100;
    assign is_subi = ir[31:22] == 10'b1101000100;
    assign is_ldur = ir[31:21] == 11'b11111000010;
    assign is_stur = ir[31:21] == 11'b11111000000;
    assign is_b    = ir[31:26] == 6'b000101;
    assign is_cbz  = ir[31:24] == 8'b10110100;
    assign is_r    = is_add | is_sub | is_and | is_orr;
    assign is_i    = is_addi | is_subi;

    assign alu_fs = (is_sub | is_subi) ? FS_SUB : is_and ? FS_AND : is_orr ? FS_ORR : FS_ADD;

    assign k_d9   = {{55{ir[20]}}, ir[20:12]};
    assign k_i12  = {52'd0, ir[21:10]};
    assign k_b26  = {{38{ir[25]}}, ir[25:0]};
    assign k_cb19 = {{45{ir[23]}}, ir[23:5]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            st     <= FETCH;
            ir     <= '0;
            halt_q <= 1'b0;
        end else begin
            case (st)
                FETCH: begin
                    if (bus.run) begin
                        ir <= bus.inst;
                        st <= DECODE;
                    end
                end
                DECODE: begin
                    st <= is_r ? EXR : is_i ? EXI : is_ldur ? LD1 : is_stur ? ST :
                          is_b ? BR : is_cbz ? CB1 : HALT;
                    halt_q <= !(is_r | is_i | is_ldur | is_stur | is_b | is_cbz);
                end
                LD1:     st <= LD2;
                CB1:     st <= CB2;
                HALT:    st <= HALT;
                default: st <= FETCH;
            endcase
        end
    end

    // Moore decode of the registered state and IR; CB2 alone also looks at the flags
    // that CB1 loaded, which are valid by the time CB2 is current.
    always_comb begin
        bus.sa          = '0;
        bus.sb          = '0;
        bus.da          = '0;
        bus.wr          = 1'b0;
        bus.fs          = '0;
        bus.c0          = 1'b0;
        bus.k           = '0;
        bus.m           = 1'b0;
        bus.en_alu      = 1'b0;
        bus.en_addr_alu = 1'b0;
        bus.en_b        = 1'b0;
        bus.en_pc       = 1'b0;
        bus.en_addr_pc  = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.ps          = 2'b00;
        bus.rcs         = 1'b0;
        bus.rwe         = 1'b0;
        bus.roe         = 1'b0;
        bus.sfl         = 1'b0;
        case (st)
            EXR, EXI: begin
                bus.sa     = ir[9:5];
                bus.sb     = ir[20:16];
                bus.da     = ir[4:0];
                bus.m      = st == EXI;
                bus.k      = st == EXI ? k_i12 : '0;
                bus.fs     = alu_fs;
                bus.c0     = is_sub | is_subi;
                bus.en_alu = 1'b1;
                bus.wr     = 1'b1;
                bus.ps     = 2'b01;
            end
            // Loads and stores share the address drive: Rn + sext(imm9) onto the address bus.
            LD1, LD2, ST: begin
                bus.sa          = ir[9:5];
                bus.m           = 1'b1;
                bus.k           = k_d9;
                bus.fs          = FS_ADD;
                bus.en_addr_alu = 1'b1;
                bus.rcs         = 1'b1;
                bus.roe         = st != ST;
                bus.da          = st == LD2 ? ir[4:0] : 5'd0;
                bus.wr          = st == LD2;
                bus.sb          = st == ST ? ir[4:0] : 5'd0;
                bus.en_b        = st == ST;
                bus.rwe         = st == ST;
                bus.ps          = st == LD1 ? 2'b00 : 2'b01;
            end
            BR: begin
                bus.k      = k_b26;
                bus.pc_sel = 1'b1;
                bus.ps     = 2'b11;
            end
            // Rt + 0 through the ALU so the status register captures Rt's zero flag.
            CB1: begin
                bus.sa  = ir[4:0];
                bus.m   = 1'b1;
                bus.fs  = FS_ADD;
                bus.sfl = 1'b1;
            end
            CB2: begin
                bus.k      = bus.prestat[Z_BIT] ? k_cb19 : '0;
                bus.pc_sel = bus.prestat[Z_BIT];
                bus.ps     = bus.prestat[Z_BIT] ? 2'b11 : 2'b01;
            end
            default: ;
        endcase
    end

    assign bus.halted = halt_q;
    assign bus.state  = st;
endmodule
